key_matrix_scanner: RTL and testbench
=====================================

# key_matrix_scanner

Scans an 8×8 passive key/switch matrix. It is the input-side counterpart of the team's 8×8 LED matrix driver: the same one-hot row-strobe timing and 8-bit column word. It drives one row low at a time, samples the active-low column lines, and debounces every key. It exposes the debounced 64-bit key state plus a valid/ready stream of press/release events for the application logic.

## Interface
- `SCAN_DIV`, default 27000: clock cycles per row dwell. Must be ≥ 16.
- `DEBOUNCE_SCANS`, default 4: consecutive disagreeing samples of one key needed to accept a change. Legal range is 1–15.
- `EV_DEPTH`, default 4: event FIFO depth. Must be a power of two, ≥ 2.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `row_n` out 8: one-hot active-low row strobe.
- `col_n` in 8: asynchronous column inputs. Active low, with external pull-ups.
- `keys` out 64: debounced state, 1 = pressed. Index = row*8 + col.
- `ev_valid` out 1: an event is available.
- `ev_ready` in 1: the consumer accepts the event.
- `ev_key` out 6: key index of the head event.
- `ev_pressed` out 1: 1 = press, 0 = release.
- `ev_overflow` out 1: sticky flag, set when an event was dropped.
- `ev_overflow_clr` in 1: clears `ev_overflow`.

## Operation
- **Column synchronisation:** `col_n` passes through a 2-flop synchroniser. The raw sample is r[c] = ~sync[c].
- **Row counter:** the 3-bit `row_cnt` resets to 0. `row_n` = ~(8'b1 << row_cnt), and it is registered.
- **Dwell and sampling:** a dwell counter counts 0..SCAN_DIV-1.
  - On the tick (count == SCAN_DIV-1), the 8 raw bits are captured for the current `row_cnt`.
  - In the same cycle, `row_cnt` increments modulo 8, wrapping 7→0.
- **Per-key debounce:** each key has a stable bit s (= `keys` bit) and a counter d of 4 bits. On each sample of that key:
  - If r == s: d ← 0.
  - Else if d == DEBOUNCE_SCANS-1: s ← r, d ← 0, and the key's change flag is set.
  - Else: d ← d+1.
- **Serialiser:** in the 8 cycles following a tick it walks columns 0..7 of the sampled row.
  - For each column whose change flag is set, it pushes {key, s} into the event FIFO. Events are therefore always in ascending column order.
  - Flags are cleared as they are walked.
  - SCAN_DIV ≥ 16 guarantees the walk finishes before the next tick.
- **FIFO push rules:**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `ev_overflow` ← 1.
  - `keys` is never affected by drops.
- **FIFO pop rules:** a pop happens when `ev_valid` && `ev_ready`. `ev_key`/`ev_pressed` hold steady while `ev_valid` is high and `ev_ready` is low.
- **Overflow flag priority:** if `ev_overflow_clr` and a drop occur in the same cycle, the flag ends up set (set wins).
- **Reset:** `rst` at any time, including mid-walk, clears everything in the same cycle.

## Timing
- **Reset values:** `row_n` = 8'hFE, `row_cnt` = 0, dwell = 0, `keys` = 0, all d = 0, change flags = 0, FIFO empty, `ev_valid` = 0, `ev_key` = 0, `ev_pressed` = 0, `ev_overflow` = 0.
- **Row period:** `row_n` changes 1 cycle after each tick. A row is held for exactly SCAN_DIV cycles, so a full scan takes 8·SCAN_DIV cycles.
- **Settling:** the column sample for a row is taken SCAN_DIV-1 cycles after that row's strobe asserts. This covers the 2-cycle synchroniser latency plus line settling.
- **Debounce latency:** a change is accepted at the DEBOUNCE_SCANS-th consecutive differing sample of that key.
- **Event latency:** an event appears on `ev_valid` between 2 and 9 cycles after its tick (walk position + 1 FIFO register).
- **Handshake:** the FIFO supports a throughput of 1 event per cycle.

## Configuration
- Macro: `KEY_MATRIX_EVENT_EN`.
- **Defined:** the serialiser, FIFO and event ports behave as specified above.
- **Undefined:**
  - The serialiser and FIFO are not built.
  - `ev_valid`, `ev_key`, `ev_pressed` and `ev_overflow` are tied to 0, and `ev_ready`/`ev_overflow_clr` are ignored.
  - Scanning and `keys` are unchanged.

## Structure
- **Shared package `key_matrix_pkg`:**
  - `MATRIX_ROWS` = 8 and `MATRIX_COLS` = 8.
  - typedef `key_idx_t` (logic [5:0]).
  - packed struct `key_event_t` {`key_idx_t` key; logic pressed}.
- **Sub-module `key_event_fifo`:** a synchronous FIFO of `key_event_t` with push/full/drop and valid/ready pop, parameterised by `EV_DEPTH`.

## Test plan
All scenarios use SCAN_DIV=16, DEBOUNCE_SCANS=4, EV_DEPTH=4, `KEY_MATRIX_EVENT_EN` defined.
- **Reset:** hold `rst` 2 cycles → `row_n`=8'hFE, `keys`=0, `ev_valid`=0. 16 cycles after release → `row_n`=8'hFD. 128 cycles after release → back to 8'hFE.
- **Single press:** pull `col_n[5]` low whenever `row_n[2]`=0, held → `keys[21]`=1 at the 4th row-2 sample. Exactly one event: `ev_key`=21, `ev_pressed`=1.
- **Glitch:** key 21 pressed for 3 scans only → `keys[21]` stays 0 and no event is produced.
- **Row burst with overflow:** all 8 columns of row 0 pressed, `ev_ready`=0 → `keys[7:0]`=8'hFF, FIFO holds keys 0,1,2,3 (pressed), `ev_overflow`=1. Pulse `ev_overflow_clr` → flag clears.
- **Release drain:** release row 0 with `ev_ready`=1 → 8 release events, keys 0..7 in order, `ev_pressed`=0, `ev_overflow` stays 0.
- **Reset mid-operation:** assert `rst` on cycle 3 of a walk → all outputs return to reset values the next cycle, and no further event is emitted.

Source files
------------

// File: rtl/key_matrix_pkg.sv
// Shared types and constants for the 8x8 key matrix scanner and its event FIFO.
package key_matrix_pkg;

   localparam int unsigned MATRIX_ROWS = 8;
   localparam int unsigned MATRIX_COLS = 8;
   localparam int unsigned ROW_W       = 3;
   localparam int unsigned COL_W       = 3;
   localparam int unsigned KEY_IDX_W   = 6;
   localparam int unsigned NUM_KEYS    = MATRIX_ROWS * MATRIX_COLS;
   localparam int unsigned DEB_CNT_W   = 4;

   typedef logic [KEY_IDX_W-1:0] key_idx_t;

   typedef struct packed {
      key_idx_t key;
      logic     pressed;
   } key_event_t;

   // Key index is row*8 + col, which is just the concatenation.
   function automatic key_idx_t key_index(input logic [ROW_W-1:0] row,
                                          input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO: push with full/drop reporting, valid/ready pop with registered head.
module key_event_fifo
   import key_matrix_pkg::*;
#(
   parameter int unsigned EV_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  key_event_t push_data,
   input  logic       pop_ready,
   output logic       pop_valid,
   output key_event_t pop_data,
   output logic       full_c,
   output logic       drop_c
);

   localparam int unsigned PTR_W = (EV_DEPTH > 1) ? $clog2(EV_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   key_event_t       mem_q [EV_DEPTH];
   key_event_t       mem_d [EV_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   key_event_t       head_q, head_d;
   logic             pop_c;
   logic             push_ok_c;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      full_c    = (count_q == CNT_W'(EV_DEPTH));
      pop_c     = valid_q && pop_ready;
      push_ok_c = push && (!full_c || pop_c);
      drop_c    = push && !push_ok_c;
      if (push_ok_c) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      valid_d = (count_d != '0);
      head_d  = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(EV_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   assign pop_valid = valid_q;
   assign pop_data  = head_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner with per-key debounce and optional press/release event stream.
// Event stream (serialiser, FIFO, ev_* ports) is built only with KEY_MATRIX_EVENT_EN defined.
module key_matrix_scanner
   import key_matrix_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 27000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned EV_DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [MATRIX_ROWS-1:0] row_n,
   input  logic [MATRIX_COLS-1:0] col_n,
   output logic [NUM_KEYS-1:0]    keys,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [KEY_IDX_W-1:0]   ev_key,
   output logic                   ev_pressed,
   output logic                   ev_overflow,
   input  logic                   ev_overflow_clr
);

   localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
   localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DEB_CNT_W-1:0] DEB_LAST   = DEB_CNT_W'(DEBOUNCE_SCANS - 1);

   logic [MATRIX_COLS-1:0] col_meta_q, col_sync_q;
   logic [DWELL_W-1:0]     dwell_q, dwell_d;
   logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
   logic [MATRIX_ROWS-1:0] row_n_q, row_n_d;
   logic [NUM_KEYS-1:0]    keys_q, keys_d;
   logic [DEB_CNT_W-1:0]   deb_cnt_q [NUM_KEYS];
   logic [DEB_CNT_W-1:0]   deb_cnt_d [NUM_KEYS];
   logic                   tick_c;
   logic [MATRIX_COLS-1:0] raw_c;
   logic [MATRIX_COLS-1:0] chg_set_c;
   key_idx_t               key_i;

   // Dwell timer and row sequencing; row strobe registered from the next row count.
   always_comb begin
      tick_c    = (dwell_q == DWELL_LAST);
      dwell_d   = tick_c ? '0 : dwell_q + DWELL_W'(1);
      row_cnt_d = tick_c ? row_cnt_q + ROW_W'(1) : row_cnt_q;
      row_n_d   = ~(MATRIX_ROWS'(1) << row_cnt_d);
   end

   // Debounce the eight keys of the current row on each tick.
   always_comb begin
      keys_d    = keys_q;
      deb_cnt_d = deb_cnt_q;
      chg_set_c = '0;
      key_i     = '0;
      raw_c     = ~col_sync_q;
      if (tick_c) begin
         for (int c = 0; c < int'(MATRIX_COLS); c++) begin
            key_i = key_index(row_cnt_q, COL_W'(c));
            if (raw_c[c] == keys_q[key_i]) begin
               deb_cnt_d[key_i] = '0;
            end else if (deb_cnt_q[key_i] == DEB_LAST) begin
               keys_d[key_i]    = raw_c[c];
               deb_cnt_d[key_i] = '0;
               chg_set_c[c]     = 1'b1;
            end else begin
               deb_cnt_d[key_i] = deb_cnt_q[key_i] + DEB_CNT_W'(1);
            end
         end
      end
   end

   // Synchroniser resets to the idle (pulled-up) level so no phantom presses appear.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta_q <= '1;
         col_sync_q <= '1;
         dwell_q    <= '0;
         row_cnt_q  <= '0;
         row_n_q    <= ~(MATRIX_ROWS'(1));
         keys_q     <= '0;
         for (int k = 0; k < int'(NUM_KEYS); k++) begin
            deb_cnt_q[k] <= '0;
         end
      end else begin
         col_meta_q <= col_n;
         col_sync_q <= col_meta_q;
         dwell_q    <= dwell_d;
         row_cnt_q  <= row_cnt_d;
         row_n_q    <= row_n_d;
         keys_q     <= keys_d;
         deb_cnt_q  <= deb_cnt_d;
      end
   end

   assign row_n = row_n_q;
   assign keys  = keys_q;

`ifdef KEY_MATRIX_EVENT_EN

   logic                   walk_act_q, walk_act_d;
   logic [COL_W-1:0]       walk_col_q, walk_col_d;
   logic [ROW_W-1:0]       walk_row_q, walk_row_d;
   logic [MATRIX_COLS-1:0] chg_q, chg_d;
   logic                   overflow_q, overflow_d;
   logic                   push_c;
   key_event_t             push_ev_c;
   key_idx_t               walk_key_c;
   logic                   drop_c;
   logic                   unused_fifo_full;
   key_event_t             head_c;

   // Serialiser: walk columns 0..7 of the sampled row, one per cycle after the tick.
   always_comb begin
      walk_act_d = walk_act_q;
      walk_col_d = walk_col_q;
      walk_row_d = walk_row_q;
      chg_d      = chg_q;
      push_c     = 1'b0;
      walk_key_c = key_index(walk_row_q, walk_col_q);
      push_ev_c  = '{key: walk_key_c, pressed: keys_q[walk_key_c]};
      if (walk_act_q) begin
         push_c             = chg_q[walk_col_q];
         chg_d[walk_col_q]  = 1'b0;
         walk_col_d         = walk_col_q + COL_W'(1);
         if (walk_col_q == COL_W'(MATRIX_COLS - 1)) begin
            walk_act_d = 1'b0;
         end
      end
      if (tick_c) begin
         chg_d      = chg_set_c;
         walk_act_d = 1'b1;
         walk_col_d = '0;
         walk_row_d = row_cnt_q;
      end
      overflow_d = (overflow_q && !ev_overflow_clr) || drop_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         walk_act_q <= 1'b0;
         walk_col_q <= '0;
         walk_row_q <= '0;
         chg_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         walk_act_q <= walk_act_d;
         walk_col_q <= walk_col_d;
         walk_row_q <= walk_row_d;
         chg_q      <= chg_d;
         overflow_q <= overflow_d;
      end
   end

   key_event_fifo #(
      .EV_DEPTH (EV_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_c),
      .push_data (push_ev_c),
      .pop_ready (ev_ready),
      .pop_valid (ev_valid),
      .pop_data  (head_c),
      .full_c    (unused_fifo_full),
      .drop_c    (drop_c)
   );

   assign ev_key      = head_c.key;
   assign ev_pressed  = head_c.pressed;
   assign ev_overflow = overflow_q;

`else

   logic unused_ev_inputs;
   assign unused_ev_inputs = ^{ev_ready, ev_overflow_clr, chg_set_c};

   assign ev_valid    = 1'b0;
   assign ev_key      = '0;
   assign ev_pressed  = 1'b0;
   assign ev_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Randomised self-checking bench for key_matrix_scanner against a scan-level reference model.
module tb_key_matrix_scanner;

   localparam int unsigned SCAN_DIV = 16;
   localparam int unsigned DEB      = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int          SCAN     = 8 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  row_n;
   logic [7:0]  col_n;
   logic [63:0] keys;
   logic        ev_valid;
   logic        ev_ready;
   logic [5:0]  ev_key;
   logic        ev_pressed;
   logic        ev_overflow;
   logic        ev_overflow_clr;

   logic [63:0] phys;

   key_matrix_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB),
      .EV_DEPTH       (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .row_n           (row_n),
      .col_n           (col_n),
      .keys            (keys),
      .ev_valid        (ev_valid),
      .ev_ready        (ev_ready),
      .ev_key          (ev_key),
      .ev_pressed      (ev_pressed),
      .ev_overflow     (ev_overflow),
      .ev_overflow_clr (ev_overflow_clr)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed switch pulls its column low while its row is strobed.
   always_comb begin
      col_n = 8'hFF;
      for (int r = 0; r < 8; r++) begin
         if (!row_n[r]) begin
            for (int c = 0; c < 8; c++) begin
               if (phys[r*8+c]) col_n[c] = 1'b0;
            end
         end
      end
   end

   // Reference model state (after the most recent clock edge)
   int          m_dwell, m_row, m_wpos, m_wrow;
   logic [63:0] m_keys;
   int          m_cnt [64];
   logic [7:0]  m_flags;
   logic [6:0]  m_q [$];
   bit          m_ovf;

   int n_cmp, n_err;
   int pops_k21, pops_rel, valid_cycles;
   int rel_keys [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_dwell = 0; m_row = 0; m_wpos = 8; m_wrow = 0;
      m_keys = '0; m_flags = '0; m_ovf = 1'b0;
      for (int i = 0; i < 64; i++) m_cnt[i] = 0;
      m_q.delete();
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit pop, push, r;
      logic [6:0] ev;
      int idx;
      if (rst) begin
         model_reset();
         return;
      end
      pop = (m_q.size() != 0) && ev_ready;
      push = 1'b0;
      ev = '0;
      if (m_wpos < 8 && m_flags[m_wpos]) begin
         idx  = m_wrow * 8 + m_wpos;
         push = 1'b1;
         ev   = {6'(idx), m_keys[idx]};
      end
      if (ev_overflow_clr) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(ev);
         else m_ovf = 1'b1;
      end
      if (m_wpos < 8) m_wpos++;
      if (m_dwell == SCAN_DIV - 1) begin
         m_flags = '0;
         for (int c = 0; c < 8; c++) begin
            idx = m_row * 8 + c;
            r = phys[idx];
            if (r == m_keys[idx]) m_cnt[idx] = 0;
            else if (m_cnt[idx] == DEB - 1) begin
               m_keys[idx] = r;
               m_cnt[idx]  = 0;
               m_flags[c]  = 1'b1;
            end else m_cnt[idx]++;
         end
         m_wrow  = m_row;
         m_wpos  = 0;
         m_row   = (m_row + 1) % 8;
         m_dwell = 0;
      end else begin
         m_dwell++;
      end
   endtask

   task automatic check_outputs();
      logic [7:0] exp_row;
      exp_row = ~(8'(1) << m_row);
      chk("row_n", 64'(row_n), 64'(exp_row));
      chk("keys", keys, m_keys);
`ifdef KEY_MATRIX_EVENT_EN
      chk("ev_valid", 64'(ev_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("ev_key", 64'(ev_key), 64'(m_q[0][6:1]));
         chk("ev_pressed", 64'(ev_pressed), 64'(m_q[0][0]));
      end
      chk("ev_overflow", 64'(ev_overflow), 64'(m_ovf));
`else
      chk("ev_valid_off", 64'(ev_valid), 64'(0));
      chk("ev_key_off", 64'(ev_key), 64'(0));
      chk("ev_overflow_off", 64'(ev_overflow), 64'(0));
`endif
      if (ev_valid) valid_cycles++;
      if (ev_valid && ev_ready) begin
         if (ev_key == 6'd21) pops_k21++;
         if (!ev_pressed) begin
            pops_rel++;
            rel_keys.push_back(int'(ev_key));
         end
      end
   endtask

   // One clock: check at the negedge, then let the model and DUT take the edge.
   task automatic step();
      check_outputs();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic sync_scan();
      for (int i = 0; i < 2 * SCAN && !(m_row == 0 && m_dwell == 0); i++) step();
      chk("sync_scan_row", 64'(row_n), 64'(8'hFE));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_row_n"}, 64'(row_n), 64'(8'hFE));
      chk({tag, "_keys"}, keys, 64'(0));
      chk({tag, "_ev_valid"}, 64'(ev_valid), 64'(0));
      chk({tag, "_ev_key"}, 64'(ev_key), 64'(0));
      chk({tag, "_ev_pressed"}, 64'(ev_pressed), 64'(0));
      chk({tag, "_ev_overflow"}, 64'(ev_overflow), 64'(0));
   endtask

   initial begin
      int n, k;
      bit found;
      n_cmp = 0; n_err = 0;
      pops_k21 = 0; pops_rel = 0; valid_cycles = 0;
      rst = 1'b1; ev_ready = 1'b1; ev_overflow_clr = 1'b0; phys = '0;
      model_reset();

      // Reset: first edge brings the DUT out of X, second is checked
      @(negedge clk);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      step();
      check_reset_values("reset");
      rst = 1'b0;
      run(16);
      chk("row_after_16", 64'(row_n), 64'(8'hFD));
      run(112);
      chk("row_after_128", 64'(row_n), 64'(8'hFE));

      // Single press of key 21 (row 2, col 5)
      pops_k21 = 0;
      phys[21] = 1'b1;
      run(3 * SCAN);
      chk("press_after_3_samples", 64'(keys[21]), 64'(0));
      run(SCAN);
      chk("press_after_4_samples", 64'(keys[21]), 64'(1));
      run(SCAN);
`ifdef KEY_MATRIX_EVENT_EN
      chk("press_event_count", 64'(pops_k21), 64'(1));
`endif

      // Release, then a 3-scan glitch that must be rejected
      phys[21] = 1'b0;
      run(5 * SCAN);
      chk("release_21", 64'(keys[21]), 64'(0));
      pops_k21 = 0;
      phys[21] = 1'b1;
      run(3 * SCAN);
      phys[21] = 1'b0;
      run(5 * SCAN);
      chk("glitch_keys", 64'(keys[21]), 64'(0));
      chk("glitch_events", 64'(pops_k21), 64'(0));

      // Row burst with a stalled consumer overflows the FIFO
      ev_ready = 1'b0;
      phys[7:0] = 8'hFF;
      run(5 * SCAN);
      chk("burst_keys", 64'(keys[7:0]), 64'(8'hFF));
`ifdef KEY_MATRIX_EVENT_EN
      chk("burst_overflow", 64'(ev_overflow), 64'(1));
      chk("burst_head_key", 64'(ev_key), 64'(0));
`endif
      ev_overflow_clr = 1'b1;
      step();
      ev_overflow_clr = 1'b0;
      step();
      chk("overflow_cleared", 64'(ev_overflow), 64'(0));
      sync_scan();

      // Release drain with the consumer always ready
      ev_ready = 1'b1;
      pops_rel = 0;
      rel_keys.delete();
      phys[7:0] = 8'h00;
      run(6 * SCAN);
      chk("drain_keys", 64'(keys[7:0]), 64'(0));
      chk("drain_overflow", 64'(ev_overflow), 64'(0));
`ifdef KEY_MATRIX_EVENT_EN
      chk("drain_release_count", 64'(pops_rel), 64'(8));
      for (int i = 0; i < rel_keys.size() && i < 8; i++)
         chk("drain_release_order", 64'(rel_keys[i]), 64'(i));
`endif

      // Randomised presses, stalls and overflow clears
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 63);
            phys[k] = ~phys[k];
         end
         n = $urandom_range(1, 16) * SCAN_DIV;
         for (int j = 0; j < n; j++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            ev_overflow_clr = ($urandom_range(0, 15) == 0);
            step();
         end
      end
      ev_overflow_clr = 1'b0;
      ev_ready = 1'b1;
      sync_scan();
      phys = '0;
      run(6 * SCAN);

      // Reset in the middle of a walk that is emitting events
      phys[31:24] = 8'hFF;
      found = 1'b0;
      for (int i = 0; i < 8 * SCAN && !found; i++) begin
         if (m_wpos == 3 && m_wrow == 3 && m_flags != 8'h00) found = 1'b1;
         else step();
      end
      chk("midwalk_found", 64'(keys[31:24]), 64'(8'hFF));
      phys = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_values("midwalk_reset");
      valid_cycles = 0;
      run(5 * SCAN);
      chk("post_reset_events", 64'(valid_cycles), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
